// File: rtl/ysyx_25020047_seq_ctrl.sv
// ysyx_25020047_seq_ctrl
// ----------------------
// Multi-cycle sequencer for the ysyx_25020047 core. It walks every
// instruction through fetch (request + response), a single execute cycle,
// an optional data-memory request/response, and a write-back cycle. The
// write-back cycle is the only place the PC and register file are written.
//
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   ifu_req_valid/ready           fetch request handshake
//   ifu_rsp_valid, inst_we        fetch response; inst_we latches the IR
//   inst_type, is_load, is_store,
//   is_ebreak, rf_wen             decoded instruction attributes
//   lsu_req_valid/ready           data memory request handshake
//   lsu_rsp_valid                 load data / store acknowledge
//   pc_we, rf_we                  write-back commit strobes
//   halt, err_code                sticky stop flag and its cause
//   retire_cnt                    committed instruction counter (wraps)
//   state                         current FSM state, for debug
module ysyx_25020047_seq_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    output logic        inst_we,
    input  logic [63:0] inst_type,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_ebreak,
    input  logic        rf_wen,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        pc_we,
    output logic        rf_we,
    output logic        halt,
    output logic [1:0]  err_code,
    output logic [31:0] retire_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_IFW  = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_MEMW = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_IFU_TO  = 2'd2;
    localparam logic [1:0] ERR_LSU_TO  = 2'd3;

    // The counter holds the number of cycles already spent waiting, so the
    // last permitted wait cycle is the one where it reads TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        halt_q, halt_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] retire_q, retire_d;
    logic        timed_out;
    logic        in_wait_state;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        halt_d        = halt_q;
        err_d         = err_q;
        retire_d      = retire_q;
        timed_out     = (wait_q == WAIT_LAST);
        in_wait_state = 1'b0;

        case (state_q)
            S_IF: begin
                in_wait_state = 1'b1;
                // A handshake on the final permitted cycle still wins.
                if (ifu_req_ready) begin
                    state_d = S_IFW;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    err_d   = ERR_IFU_TO;
                end
            end
            S_IFW: begin
                in_wait_state = 1'b1;
                if (ifu_rsp_valid) begin
                    state_d = S_EX;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    err_d   = ERR_IFU_TO;
                end
            end
            S_EX: begin
                if (inst_type == '0) begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end else if (is_ebreak) begin
                    state_d = S_HALT;
                    err_d   = ERR_NONE;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                in_wait_state = 1'b1;
                if (lsu_req_ready) begin
                    state_d = S_MEMW;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    err_d   = ERR_LSU_TO;
                end
            end
            S_MEMW: begin
                in_wait_state = 1'b1;
                if (lsu_rsp_valid) begin
                    state_d = S_WB;
                end else if (timed_out) begin
                    state_d = S_HALT;
                    err_d   = ERR_LSU_TO;
                end
            end
            S_WB: begin
                retire_d = retire_q + 32'd1;
                state_d  = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Corrupted state register: stop as if the instruction were illegal.
                state_d = S_HALT;
                err_d   = ERR_ILLEGAL;
            end
        endcase

        if ((state_d == S_HALT) && (state_q != S_HALT)) begin
            halt_d = 1'b1;
        end

        // Any state change clears the counter so each wait state starts at zero.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (in_wait_state) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IF;
            wait_q   <= '0;
            halt_q   <= 1'b0;
            err_q    <= ERR_NONE;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halt_q   <= halt_d;
            err_q    <= err_d;
            retire_q <= retire_d;
        end
    end

    // The fetch request is masked while reset is held so that every strobe is
    // quiet during reset, yet it rises immediately once reset is released.
    assign ifu_req_valid = (state_q == S_IF) && !rst;
    // Mealy: the IR is loaded in the very cycle the fetch response arrives.
    assign inst_we       = (state_q == S_IFW) && ifu_rsp_valid;
    assign lsu_req_valid = (state_q == S_MEM);
    assign pc_we         = (state_q == S_WB);
    assign rf_we         = (state_q == S_WB) && rf_wen && !is_store;
    assign halt          = halt_q;
    assign err_code      = err_q;
    assign retire_cnt    = retire_q;
    assign state         = 3'(state_q);

endmodule

// File: tb/tb_ysyx_25020047_seq_ctrl.sv
// Testbench for ysyx_25020047_seq_ctrl. A responder process plays the IFU
// and LSU with configurable per-instruction delays; the stimulus process
// pushes the hand-computed commit/halt event for each instruction into a
// scoreboard queue, and a monitor process pops and compares whenever the
// DUT commits (pc_we) or halts.
module tb_ysyx_25020047_seq_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic        inst_we;
    logic [63:0] inst_type;
    logic        is_load;
    logic        is_store;
    logic        is_ebreak;
    logic        rf_wen;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        pc_we;
    logic        rf_we;
    logic        halt;
    logic [1:0]  err_code;
    logic [31:0] retire_cnt;
    logic [2:0]  state;

    ysyx_25020047_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid),
        .inst_we      (inst_we),
        .inst_type    (inst_type),
        .is_load      (is_load),
        .is_store     (is_store),
        .is_ebreak    (is_ebreak),
        .rf_wen       (rf_wen),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_valid),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .halt         (halt),
        .err_code     (err_code),
        .retire_cnt   (retire_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_halt;
        int          cyc;
        bit          rf;
        logic [1:0]  err;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Responder configuration: cycles of delay before each handshake.
    int   d_if_rdy  = 0;
    int   d_if_rsp  = 0;
    int   d_ls_rdy  = 0;
    int   d_ls_rsp  = 0;
    bit   stray_ifu = 1'b0;
    bit   stray_lsu = 1'b0;

    // Monitor state.
    int          mon_cyc   = 0;
    bit          prev_halt = 1'b0;
    bit          pend      = 1'b0;
    logic [31:0] pend_ret  = '0;

    localparam logic [63:0] T_ADDI = 64'h1;
    localparam logic [63:0] T_ADD  = 64'h2;
    localparam logic [63:0] T_JAL  = 64'h4;
    localparam logic [63:0] T_LW   = 64'h8;
    localparam logic [63:0] T_SW   = 64'h10;
    localparam logic [63:0] T_BEQ  = 64'h20;
    localparam logic [63:0] T_EBRK = 64'h40;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Memory responder: drives handshake inputs on the falling edge.
    initial begin
        int          rcnt;
        logic [2:0]  prev_st;
        rcnt          = 0;
        prev_st       = 3'd7;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rcnt          = 0;
                prev_st       = 3'd7;
                ifu_req_ready = 1'b0;
                ifu_rsp_valid = 1'b0;
                lsu_req_ready = 1'b0;
                lsu_rsp_valid = 1'b0;
            end else begin
                if (state != prev_st) rcnt = 0;
                else rcnt++;
                prev_st       = state;
                ifu_req_ready = ifu_req_valid && (rcnt >= d_if_rdy);
                ifu_rsp_valid = ((state == 3'd1) && (rcnt >= d_if_rsp)) || stray_ifu;
                lsu_req_ready = (lsu_req_valid && (rcnt >= d_ls_rdy)) || stray_lsu;
                lsu_rsp_valid = ((state == 3'd4) && (rcnt >= d_ls_rsp)) || stray_lsu;
            end
        end
    end

    // Monitor: cycle 1 is the first clock period after reset release.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_cyc   = 0;
                prev_halt = 1'b0;
                pend      = 1'b0;
            end else begin
                mon_cyc++;
                if (pend) begin
                    checkOutput("retire_cnt_after_wb", retire_cnt, pend_ret);
                    pend = 1'b0;
                end
                if (pc_we) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL commit_expected: got commit at cycle %0d, expected none", mon_cyc);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("event_is_halt", 32'(0), 32'(e.is_halt));
                        checkOutput("commit_cycle", 32'(mon_cyc), 32'(e.cyc));
                        checkOutput("commit_rf_we", 32'(rf_we), 32'(e.rf));
                        pend     = 1'b1;
                        pend_ret = e.ret;
                    end
                end
                if (halt && !prev_halt) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL halt_expected: got halt at cycle %0d, expected none", mon_cyc);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("event_is_halt", 32'(1), 32'(e.is_halt));
                        checkOutput("halt_cycle", 32'(mon_cyc), 32'(e.cyc));
                        checkOutput("halt_err_code", 32'(err_code), 32'(e.err));
                        checkOutput("halt_state", 32'(state), 32'(6));
                        checkOutput("halt_retire_cnt", retire_cnt, e.ret);
                    end
                end
                prev_halt = halt;
            end
        end
    end

    task automatic doReset();
        #1 rst = 1'b1;
        stray_ifu = 1'b0;
        stray_lsu = 1'b0;
        #1;
        checkOutput("rst_state", 32'(state), 32'(0));
        checkOutput("rst_halt", 32'(halt), 32'(0));
        checkOutput("rst_err_code", 32'(err_code), 32'(0));
        checkOutput("rst_retire_cnt", retire_cnt, 32'(0));
        checkOutput("rst_pc_we", 32'(pc_we), 32'(0));
        checkOutput("rst_rf_we", 32'(rf_we), 32'(0));
        checkOutput("rst_ifu_req_valid", 32'(ifu_req_valid), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("ifu_req_valid_after_rst", 32'(ifu_req_valid), 32'(1));
    endtask

    task automatic setInst(input logic [63:0] itype, input bit ld, input bit st,
                           input bit eb, input bit wen, input int ifr, input int ifs,
                           input int lsr, input int lss);
        inst_type = itype;
        is_load   = ld;
        is_store  = st;
        is_ebreak = eb;
        rf_wen    = wen;
        d_if_rdy  = ifr;
        d_if_rsp  = ifs;
        d_ls_rdy  = lsr;
        d_ls_rsp  = lss;
    endtask

    // Issue one instruction, queue its expected event, and wait (bounded)
    // until it either commits or halts the core.
    task automatic applyStimulus(input string nm, input logic [63:0] itype, input bit ld,
                                 input bit st, input bit eb, input bit wen,
                                 input int ifr, input int ifs, input int lsr, input int lss,
                                 input bit e_halt, input int e_cyc, input bit e_rf,
                                 input logic [1:0] e_err, input logic [31:0] e_ret);
        exp_t e;
        bit   done;
        setInst(itype, ld, st, eb, wen, ifr, ifs, lsr, lss);
        e.is_halt = e_halt;
        e.cyc     = e_cyc;
        e.rf      = e_rf;
        e.err     = e_err;
        e.ret     = e_ret;
        exp_q.push_back(e);
        done = 1'b0;
        for (int i = 0; (i < 100) && !done; i++) begin
            @(negedge clk);
            if (pc_we || halt) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL %s_done: got no commit or halt in 100 cycles, expected one", nm);
        end
        if (done && pc_we) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit reached;
        setInst(T_ADDI, 0, 0, 0, 1, 0, 0, 0, 0);
        $display("[TB] start");

        // Zero-wait program, then a slow load, a store, a branch.
        doReset();
        applyStimulus("addi", T_ADDI, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4, 1, 2'd0, 32'd1);
        applyStimulus("add",  T_ADD,  0, 0, 0, 1, 0, 0, 0, 0, 0, 8, 1, 2'd0, 32'd2);
        applyStimulus("jal",  T_JAL,  0, 0, 0, 1, 0, 0, 0, 0, 0, 12, 1, 2'd0, 32'd3);
        applyStimulus("lw",   T_LW,   1, 0, 0, 1, 0, 0, 2, 3, 0, 23, 1, 2'd0, 32'd4);
        applyStimulus("sw",   T_SW,   0, 1, 0, 1, 0, 0, 0, 0, 0, 29, 0, 2'd0, 32'd5);
        stray_lsu = 1'b1;
        applyStimulus("beq",  T_BEQ,  0, 0, 0, 0, 0, 0, 0, 0, 0, 33, 0, 2'd0, 32'd6);
        stray_lsu = 1'b0;

        // Reset while waiting on the load response: aborted, no commit.
        setInst(T_LW, 1, 0, 0, 1, 0, 0, 0, 3);
        reached = 1'b0;
        for (int i = 0; (i < 50) && !reached; i++) begin
            @(negedge clk);
            if (state == 3'd4) reached = 1'b1;
        end
        checkOutput("reached_memw", 32'(reached), 32'(1));
        doReset();

        // IFU never ready: halt after TIMEOUT wait cycles.
        applyStimulus("ifu_timeout", T_ADDI, 0, 0, 0, 1, 1000, 0, 0, 0, 1, 5, 0, 2'd2, 32'd0);
        doReset();

        // Ready on the last permitted cycle wins, then an illegal instruction.
        applyStimulus("ifu_ready_last", T_ADDI, 0, 0, 0, 1, 3, 0, 0, 0, 0, 7, 1, 2'd0, 32'd1);
        applyStimulus("illegal", 64'h0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 11, 0, 2'd1, 32'd1);
        stray_ifu = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("halted_state", 32'(state), 32'(6));
            checkOutput("halted_inst_we", 32'(inst_we), 32'(0));
            checkOutput("halted_err_code", 32'(err_code), 32'(1));
            checkOutput("halted_flag", 32'(halt), 32'(1));
        end
        stray_ifu = 1'b0;
        doReset();

        // LSU request never accepted.
        applyStimulus("lsu_timeout", T_LW, 1, 0, 0, 1, 0, 0, 1000, 0, 1, 8, 0, 2'd3, 32'd0);
        doReset();

        // ebreak halts cleanly with error code 0.
        applyStimulus("ebreak", T_EBRK, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 0, 2'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
